uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo_if.sv | 30 +++
 rtl/uart_rx_timeout.sv | 72 +++++++
 rtl/uart_rx_fifo.sv | 93 +++++++++
 tb/tb_uart_rx_fifo.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive FIFO.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_COUNT   = 2'd1,
        T_EXPIRED = 2'd2
    } uart_to_state_t;

    localparam int unsigned UART_RXF_DEPTH   = 16;
    localparam int unsigned UART_RXF_THRESH  = 8;
    localparam int unsigned UART_RXF_TIMEOUT = 1024;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Producer/consumer signal bundle for uart_rx_fifo; slave is the FIFO side.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH = uart_pkg::UART_RXF_DEPTH
);
    import uart_pkg::*;

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    uart_byte_t  wr_data;
    logic        wr_done;
    uart_byte_t  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [LW-1:0] level;
    logic        overflow;
    logic        ovf_clr;
    logic        timeout;
    logic        thresh_irq;

    modport master (
        output wr_data, wr_done, rd_ready, ovf_clr,
        input  rd_data, rd_valid, level, overflow, timeout, thresh_irq
    );

    modport slave (
        input  wr_data, wr_done, rd_ready, ovf_clr,
        output rd_data, rd_valid, level, overflow, timeout, thresh_irq
    );

endinterface

// File: rtl/uart_rx_timeout.sv
// Idle timeout FSM: counts cycles without FIFO activity while the FIFO holds data.
module uart_rx_timeout
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = UART_RXF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic level_nz_i,
    input  logic wr_evt_i,
    input  logic rd_evt_i,
    output logic timeout_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

    uart_to_state_t  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            evt;

    assign evt = wr_evt_i | rd_evt_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // level_nz_i reflects the level after this cycle, so emptying forces idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!level_nz_i) begin
            state_d = T_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                T_IDLE: begin
                    state_d = T_COUNT;
                    cnt_d   = '0;
                end
                T_COUNT: begin
                    if (evt) begin
                        cnt_d = '0;
                    end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                        state_d = T_EXPIRED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                T_EXPIRED: begin
                    if (evt) begin
                        state_d = T_COUNT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = T_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign timeout_o = (state_q == T_EXPIRED);

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO behind a UART receiver with sticky overflow and idle timeout.
// Optional registered threshold interrupt under UART_RX_FIFO_THRESH_IRQ_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = UART_RXF_DEPTH,
    parameter int unsigned THRESH      = UART_RXF_THRESH,
    parameter int unsigned TIMEOUT_CYC = UART_RXF_TIMEOUT
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus_io
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    if (THRESH < 1 || THRESH > DEPTH || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0)
    begin : g_bad_param
        $error("uart_rx_fifo: illegal DEPTH/THRESH");
    end

    uart_byte_t    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          pop, wr_acc, drop;

    assign pop    = (level_q != '0) && bus_io.rd_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign wr_acc = bus_io.wr_done && ((level_q < LW'(DEPTH)) || pop);
    assign drop   = bus_io.wr_done && !wr_acc;

    always_comb begin
        wptr_d     = wr_acc ? wptr_q + AW'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
        level_d    = level_q + LW'(wr_acc) - LW'(pop);
        overflow_d = drop ? 1'b1 : (bus_io.ovf_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= bus_io.wr_data;
        end
    end

    assign bus_io.rd_data  = (level_q == '0) ? 8'h00 : mem_q[rptr_q];
    assign bus_io.rd_valid = (level_q != '0);
    assign bus_io.level    = level_q;
    assign bus_io.overflow = overflow_q;

    uart_rx_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .level_nz_i (level_d != '0),
        .wr_evt_i   (wr_acc),
        .rd_evt_i   (pop),
        .timeout_o  (bus_io.timeout)
    );

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    logic thresh_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_q <= 1'b0;
        end else begin
            thresh_q <= (level_d >= LW'(THRESH));
        end
    end

    assign bus_io.thresh_irq = thresh_q;
`else
    assign bus_io.thresh_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed steps then randomized traffic vs a queue model.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned THRESH = 8;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DEPTH       (DEPTH),
        .THRESH      (THRESH),
        .TIMEOUT_CYC (TO)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    // Reference model: contents queue, sticky flag, cycles since last activity.
    uart_byte_t mq[$];
    bit         m_ovf;
    int         m_idle;
    int         vecs;
    int         errs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_data, e_to, e_th;
        e_data = (mq.size() != 0) ? 32'(mq[0]) : 32'h0;
        e_to   = ((mq.size() != 0) && (m_idle >= int'(TO))) ? 32'd1 : 32'd0;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        e_th   = (mq.size() >= int'(THRESH)) ? 32'd1 : 32'd0;
`else
        e_th   = 32'd0;
`endif
        chk("level",    32'(bus.level),    32'(mq.size()));
        chk("rd_valid", 32'(bus.rd_valid), (mq.size() != 0) ? 32'd1 : 32'd0);
        chk("rd_data",  32'(bus.rd_data),  e_data);
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("timeout",  32'(bus.timeout),  e_to);
        chk("thresh",   32'(bus.thresh_irq), e_th);
    endtask

    task automatic cycle(input logic wd, input uart_byte_t d, input logic rr, input logic clr);
        bit pop, acc;
        bus.wr_done = wd;
        bus.wr_data = d;
        bus.rd_ready = rr;
        bus.ovf_clr = clr;
        pop = (mq.size() != 0) && rr;
        acc = wd && ((mq.size() < int'(DEPTH)) || pop);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(d);
        if (wd && !acc) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (acc || pop || mq.size() == 0) m_idle = 0;
        else if (m_idle < 100000) m_idle++;
        #1;
        bus.wr_done = 1'b0;
        bus.rd_ready = 1'b0;
        bus.ovf_clr = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_idle = 0;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        int pw, pr;
        int pw_tab[6] = '{50, 90, 10, 60, 5, 30};
        int pr_tab[6] = '{50, 10, 90, 60, 5, 70};
        uart_byte_t exp_b;
        vecs = 0;
        errs = 0;
        bus.wr_data = '0;
        bus.wr_done = 1'b0;
        bus.rd_ready = 1'b0;
        bus.ovf_clr = 1'b0;

        // Reset values
        do_reset();

        // Three bytes in, read back in order; write at empty with rd_ready must not pop
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        chk("wr_empty_no_pop", 32'(bus.level), 32'd1);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        chk("lvl3", 32'(bus.level), 32'd3);
        chk("head11", 32'(bus.rd_data), 32'h11);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("head22", 32'(bus.rd_data), 32'h22);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("head33", 32'(bus.rd_data), 32'h33);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("valid_drop", 32'(bus.rd_valid), 32'd0);
        chk("empty_data", 32'(bus.rd_data), 32'h0);

        // 17 writes: last dropped, overflow set
        for (int i = 0; i <= 16; i++) cycle(1'b1, uart_byte_t'(i), 1'b0, 1'b0);
        chk("full_level", 32'(bus.level), 32'd16);
        chk("full_ovf", 32'(bus.overflow), 32'd1);
        chk("full_head", 32'(bus.rd_data), 32'h00);

        // Clear collides with another drop: set wins, then plain clear
        cycle(1'b1, 8'h55, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Write with pop at full: accepted, no overflow
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("full_wrpop_lvl", 32'(bus.level), 32'd16);
        chk("full_wrpop_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? uart_byte_t'(i + 1) : 8'hA5;
            chk("drain_order", 32'(bus.rd_data), 32'(exp_b));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drained", 32'(bus.level), 32'd0);

        // Timeout 8 cycles after a single write, cleared by the pop
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("to_early", 32'(bus.timeout), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("to_fire", 32'(bus.timeout), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("to_clear", 32'(bus.timeout), 32'd0);
        chk("to_idle", 32'(u_dut.u_timeout.state_q), 32'(T_IDLE));

        // Threshold: 8 writes then one pop (model checks thresh_irq each cycle)
        for (int i = 0; i < 8; i++) cycle(1'b1, uart_byte_t'($urandom), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Mid-operation reset discards data; next write accepted normally
        do_reset();
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_head", 32'(bus.rd_data), 32'h3C);

        // Randomized traffic in phases of differing write/pop pressure
        for (int i = 0; i < 1800; i++) begin
            pw = pw_tab[(i / 300) % 6];
            pr = pr_tab[(i / 300) % 6];
            if (i == 950) do_reset();
            cycle(($urandom_range(0, 99) < pw), uart_byte_t'($urandom),
                  ($urandom_range(0, 99) < pr), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
